// File: rtl/sim_mem_pkg.sv
// sim_mem_pkg: shared types and constants for the simulation memory model.
//   mem_state_e          - bus-slave FSM states
//   DEFAULT_* constants  - MMIO addresses and the pass signature
//   BUS_ERROR_DATA       - read data returned for out-of-range accesses
//   LFSR_SEED/LFSR_TAPS  - stall-generator LFSR reset value and Galois taps
//   merge_bytes()        - byte-lane write merge
package sim_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  localparam logic [31:0] DEFAULT_CONSOLE_ADDR = 32'h1000_0000;
  localparam logic [31:0] DEFAULT_PASS_ADDR    = 32'h2000_0000;
  localparam logic [31:0] DEFAULT_PASS_VALUE   = 32'd123456789;
  localparam logic [31:0] BUS_ERROR_DATA       = 32'hDEAD_BEEF;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sim_mem_lfsr.sv
// sim_mem_lfsr: 16-bit Galois LFSR that free-runs every cycle; its two low
// bits pick the random extra wait cycles of the memory model.
//   clock     - sole clock
//   reset     - synchronous active-high, reloads LFSR_SEED
//   rand_bits - lfsr[1:0]
module sim_mem_lfsr
  import sim_mem_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  output logic [1:0] rand_bits
);

  logic [15:0] lfsr;

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  assign rand_bits = lfsr[1:0];

endmodule

// File: rtl/sim_mem_model.sv
// sim_mem_model: picorv32 native-bus SRAM slave for simulation, with a
// console byte port, a pass/fail signature register and bus-error flagging.
//   clock, reset                 - sole clock, synchronous active-high reset
//   mem_valid/addr/wdata/wstrb   - request, held stable until mem_ready
//   mem_ready, mem_rdata         - one-cycle registered response
//   tests_passed, tests_failed   - sticky result of writes to PASS_ADDR
//   bus_error                    - sticky, set by accesses beyond the SRAM
//   console_valid, console_data  - one-cycle byte strobe from CONSOLE_ADDR
//
// state   | meaning
// IDLE    | waiting for mem_valid
// WAIT    | counting down fixed latency plus random stall cycles
// RESP    | mem_ready/mem_rdata presented; writes commit at the closing edge
module sim_mem_model
  import sim_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS  = 65536,
  parameter int          LATENCY      = 0,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [31:0] CONSOLE_ADDR = DEFAULT_CONSOLE_ADDR,
  parameter logic [31:0] PASS_ADDR    = DEFAULT_PASS_ADDR,
  parameter logic [31:0] PASS_VALUE   = DEFAULT_PASS_VALUE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        tests_passed,
  output logic        tests_failed,
  output logic        bus_error,
  output logic        console_valid,
  output logic [7:0]  console_data
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0] sram [DEPTH_WORDS];

  mem_state_e  state, state_next;
  logic [4:0]  cnt, cnt_next;
  logic        enter_resp;
  logic [1:0]  rand_bits;
  logic [4:0]  stall_cycles;
  logic [4:0]  load_cnt;

  logic [29:0] word_idx;
  logic        is_console, is_pass, is_mmio, in_range, is_write;
  logic [31:0] rd_data;
  logic        unused_addr_lsbs;

  sim_mem_lfsr u_lfsr (
    .clock     (clock),
    .reset     (reset),
    .rand_bits (rand_bits)
  );

  // Byte offset within a word never matters: the bus is word-wide.
  assign unused_addr_lsbs = ^mem_addr[1:0];

  assign word_idx   = mem_addr[31:2];
  assign is_console = (word_idx == CONSOLE_ADDR[31:2]);
  assign is_pass    = (word_idx == PASS_ADDR[31:2]);
  assign is_mmio    = is_console || is_pass;
  assign in_range   = ({2'b00, word_idx} < 32'(DEPTH_WORDS));
  assign is_write   = |mem_wstrb;

  assign stall_cycles = STALL_EN ? {3'b000, rand_bits} : 5'd0;
  assign load_cnt     = 5'(LATENCY) + stall_cycles;

  always_comb begin
    if (is_mmio) begin
      rd_data = 32'h0000_0000;
    end else if (!in_range) begin
      rd_data = BUS_ERROR_DATA;
    end else begin
      rd_data = sram[word_idx[AW-1:0]];
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid) begin
          if (load_cnt != 5'd0) begin
            state_next = ST_WAIT;
            cnt_next   = load_cnt;
          end else begin
            state_next = ST_RESP;
            enter_resp = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        cnt_next = cnt - 5'd1;
        if (cnt_next == 5'd0) begin
          state_next = ST_RESP;
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      cnt           <= 5'd0;
      mem_ready     <= 1'b0;
      mem_rdata     <= 32'h0000_0000;
      tests_passed  <= 1'b0;
      tests_failed  <= 1'b0;
      bus_error     <= 1'b0;
      console_valid <= 1'b0;
      console_data  <= 8'h00;
    end else begin
      state         <= state_next;
      cnt           <= cnt_next;
      mem_ready     <= enter_resp;
      // RESP lasts one cycle, so loading only on entry keeps rdata zero elsewhere.
      mem_rdata     <= enter_resp ? rd_data : 32'h0000_0000;
      console_valid <= 1'b0;
      if (state == ST_RESP) begin
        if (is_console && mem_wstrb[0]) begin
          console_valid <= 1'b1;
          console_data  <= mem_wdata[7:0];
        end
        if (is_pass && is_write) begin
          if (mem_wdata == PASS_VALUE) tests_passed <= 1'b1;
          else                         tests_failed <= 1'b1;
        end
        if (!is_mmio && !in_range) bus_error <= 1'b1;
      end
    end
  end

  // Array kept out of the reset branch so preloaded contents survive reset.
  always_ff @(posedge clock) begin
    if (!reset && state == ST_RESP && is_write && !is_mmio && in_range) begin
      sram[word_idx[AW-1:0]] <= merge_bytes(sram[word_idx[AW-1:0]], mem_wdata, mem_wstrb);
    end
  end

endmodule

// File: tb/tb_sim_mem_model.sv
module tb_sim_mem_model;

  localparam logic [31:0] CON_A  = 32'h1000_0000;
  localparam logic [31:0] PASS_A = 32'h2000_0000;
  localparam logic [31:0] PASS_V = 32'd123456789;

  logic        clock;
  logic        rst         [3];
  logic        mem_valid   [3];
  logic        mem_ready   [3];
  logic [31:0] mem_addr    [3];
  logic [31:0] mem_wdata   [3];
  logic [3:0]  mem_wstrb   [3];
  logic [31:0] mem_rdata   [3];
  logic        t_pass      [3];
  logic        t_fail      [3];
  logic        b_err       [3];
  logic        con_v       [3];
  logic [7:0]  con_d       [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model [int];

  // d0: LATENCY 0, 1024 words; d1: LATENCY 3, default depth; d2: LATENCY 5 + stalls, 1024 words
  sim_mem_model #(.DEPTH_WORDS(1024), .LATENCY(0), .STALL_EN(1'b0)) dut0 (
    .clock(clock), .reset(rst[0]), .mem_valid(mem_valid[0]), .mem_ready(mem_ready[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_rdata(mem_rdata[0]), .tests_passed(t_pass[0]), .tests_failed(t_fail[0]),
    .bus_error(b_err[0]), .console_valid(con_v[0]), .console_data(con_d[0]));

  sim_mem_model #(.LATENCY(3), .STALL_EN(1'b0)) dut1 (
    .clock(clock), .reset(rst[1]), .mem_valid(mem_valid[1]), .mem_ready(mem_ready[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_rdata(mem_rdata[1]), .tests_passed(t_pass[1]), .tests_failed(t_fail[1]),
    .bus_error(b_err[1]), .console_valid(con_v[1]), .console_data(con_d[1]));

  sim_mem_model #(.DEPTH_WORDS(1024), .LATENCY(5), .STALL_EN(1'b1)) dut2 (
    .clock(clock), .reset(rst[2]), .mem_valid(mem_valid[2]), .mem_ready(mem_ready[2]),
    .mem_addr(mem_addr[2]), .mem_wdata(mem_wdata[2]), .mem_wstrb(mem_wstrb[2]),
    .mem_rdata(mem_rdata[2]), .tests_passed(t_pass[2]), .tests_failed(t_fail[2]),
    .bus_error(b_err[2]), .console_valid(con_v[2]), .console_data(con_d[2]));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Latency counts edges from the one that samples mem_valid to the first
  // sample point that sees mem_ready. Returns one cycle after the RESP cycle.
  task automatic access(input int d, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, output logic [31:0] rd, output int lat);
    bit got;
    got = 1'b0;
    lat = 0;
    mem_valid[d] = 1'b1;
    mem_addr[d]  = addr;
    mem_wdata[d] = wd;
    mem_wstrb[d] = ws;
    while (!got && lat < 40) begin
      tick();
      lat++;
      if (mem_ready[d]) got = 1'b1;
    end
    chk($sformatf("ready_seen_d%0d", d), {31'd0, got}, 32'd1);
    rd = mem_rdata[d];
    tick();
    mem_valid[d] = 1'b0;
    mem_wstrb[d] = 4'h0;
    chk($sformatf("ready_one_cycle_d%0d", d), {31'd0, mem_ready[d]}, 32'd0);
    chk($sformatf("rdata_zero_idle_d%0d", d), mem_rdata[d], 32'd0);
  endtask

  function automatic logic [31:0] byte_mask(input logic [3:0] ws);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) if (ws[i]) m = m | (32'hFF << (8 * i));
    return m;
  endfunction

  task automatic chk_lat(input int d, input int lat);
    if (d == 0)      chk("lat_d0", lat, 32'd1);
    else if (d == 1) chk("lat_d1", lat, 32'd4);
    else             chk("lat_d2_range", {31'd0, (lat >= 6 && lat <= 9)}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          lat;
    bit          saw_ready;

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; mem_valid[d] = 1'b0; mem_addr[d] = 32'd0;
      mem_wdata[d] = 32'd0; mem_wstrb[d] = 4'h0;
    end
    repeat (3) @(posedge clock);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    for (int d = 0; d < 3; d++) begin
      chk("rst_ready", {31'd0, mem_ready[d]}, 32'd0);
      chk("rst_rdata", mem_rdata[d], 32'd0);
      chk("rst_flags", {27'd0, t_pass[d], t_fail[d], b_err[d], con_v[d], 1'b0}, 32'd0);
      chk("rst_con_data", {24'd0, con_d[d]}, 32'd0);
    end

    // zero-latency write then read back
    access(0, 32'h100, 32'hA5A5_1234, 4'hF, rd, lat);
    chk("l0_write_lat", lat, 32'd1);
    access(0, 32'h100, 32'h0, 4'h0, rd, lat);
    chk("l0_read_lat", lat, 32'd1);
    chk("l0_read_data", rd, 32'hA5A5_1234);

    // partial-lane write, unaligned address ignores the byte offset
    access(0, 32'h200, 32'h1122_3344, 4'hF, rd, lat);
    access(0, 32'h202, 32'hFFFF_FFFF, 4'b0101, rd, lat);
    access(0, 32'h200, 32'h0, 4'h0, rd, lat);
    chk("wstrb_merge", rd, 32'h11FF_33FF);

    // latency 3
    access(1, 32'h40, 32'hCAFE_F00D, 4'hF, rd, lat);
    chk("l3_write_lat", lat, 32'd4);
    access(1, 32'h40, 32'h0, 4'h0, rd, lat);
    chk("l3_read_lat", lat, 32'd4);
    chk("l3_read_data", rd, 32'hCAFE_F00D);

    // console
    access(1, CON_A, 32'hAABB_CC41, 4'h1, rd, lat);
    chk("con_valid_pulse", {31'd0, con_v[1]}, 32'd1);
    chk("con_data", {24'd0, con_d[1]}, 32'h41);
    tick();
    chk("con_valid_drop", {31'd0, con_v[1]}, 32'd0);
    access(1, CON_A, 32'h0000_0042, 4'b0010, rd, lat);
    chk("con_lane0_off", {31'd0, con_v[1]}, 32'd0);

    // pass / fail signature, sticky
    access(0, PASS_A, PASS_V, 4'hF, rd, lat);
    chk("pass_set", {30'd0, t_pass[0], t_fail[0]}, 32'b10);
    access(0, PASS_A, 32'd5, 4'hF, rd, lat);
    chk("pass_sticky_fail_set", {30'd0, t_pass[0], t_fail[0]}, 32'b11);
    access(1, PASS_A, 32'd7, 4'hF, rd, lat);
    chk("fail_only", {30'd0, t_pass[1], t_fail[1]}, 32'b01);
    access(1, PASS_A, PASS_V, 4'hF, rd, lat);
    chk("fail_sticky", {30'd0, t_pass[1], t_fail[1]}, 32'b11);

    // MMIO read returns zero with normal latency
    access(1, PASS_A, 32'h0, 4'h0, rd, lat);
    chk("mmio_read_lat", lat, 32'd4);
    chk("mmio_read_data", rd, 32'd0);

    // out-of-range on the 1024-word instance
    chk("berr_clear", {31'd0, b_err[0]}, 32'd0);
    access(0, 32'h0, 32'h0BAD_F00D, 4'hF, rd, lat);
    access(0, 32'h1000, 32'h0, 4'h0, rd, lat);
    chk("oor_read_data", rd, 32'hDEAD_BEEF);
    chk("berr_set", {31'd0, b_err[0]}, 32'd1);
    access(0, 32'h1000, 32'h1234_5678, 4'hF, rd, lat);
    access(0, 32'h0, 32'h0, 4'h0, rd, lat);
    chk("oor_write_no_alias", rd, 32'h0BAD_F00D);
    chk("berr_sticky", {31'd0, b_err[0]}, 32'd1);

    // reset during WAIT of a write on the LATENCY 5 instance
    access(2, 32'h80, 32'h55AA_55AA, 4'hF, rd, lat);
    chk_lat(2, lat);
    mem_valid[2] = 1'b1; mem_addr[2] = 32'h80; mem_wdata[2] = 32'h1234_5678; mem_wstrb[2] = 4'hF;
    tick();
    tick();
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    mem_valid[2] = 1'b0; mem_wstrb[2] = 4'h0;
    saw_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (mem_ready[2]) saw_ready = 1'b1;
      tick();
    end
    chk("abort_no_ready", {31'd0, saw_ready}, 32'd0);
    access(2, 32'h80, 32'h0, 4'h0, rd, lat);
    chk_lat(2, lat);
    chk("abort_no_write", rd, 32'h55AA_55AA);

    // randomized traffic against a byte-lane memory model
    for (int d = 0; d < 3; d += 2) begin
      for (int w = 0; w < 8; w++) begin
        logic [31:0] v;
        v = $urandom;
        access(d, 32'h300 + 32'(4 * w), v, 4'hF, rd, lat);
        model[d * 4096 + w] = v;
      end
      for (int k = 0; k < 30; k++) begin
        int          w;
        logic [31:0] v, a, m;
        logic [3:0]  ws;
        w  = $urandom_range(0, 7);
        v  = $urandom;
        ws = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) ws = 4'h0;
        a  = 32'h300 + 32'(4 * w) + 32'($urandom_range(0, 3));
        access(d, a, v, ws, rd, lat);
        chk_lat(d, lat);
        if (ws == 4'h0) begin
          chk($sformatf("rand_read_d%0d_w%0d", d, w), rd, model[d * 4096 + w]);
        end else begin
          m = byte_mask(ws);
          model[d * 4096 + w] = (model[d * 4096 + w] & ~m) | (v & m);
        end
      end
      for (int w = 0; w < 8; w++) begin
        access(d, 32'h300 + 32'(4 * w), 32'h0, 4'h0, rd, lat);
        chk($sformatf("rand_final_d%0d_w%0d", d, w), rd, model[d * 4096 + w]);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
